// File: rtl/tmp421_sensor_ctrl_if.sv
// ---------------------------------------------------------------------------
// tmp421_sensor_ctrl_if
// Handshake between the sensor controller and the TMP421 I2C transfer FSM.
//   query_local  : controller -> I2C FSM, one-cycle request to read the local sensor
//   query_remote : controller -> I2C FSM, one-cycle request to read the remote sensor
//   done         : I2C FSM -> controller, transfer complete, bytes valid this cycle
//   error        : I2C FSM -> controller, transfer failed
//   byte0        : temperature LSB byte "llll00ff"
//   byte1        : temperature MSB byte "mmmmmmmm"
// Modports: master = sensor controller side, slave = I2C FSM side.
// ---------------------------------------------------------------------------
interface tmp421_sensor_ctrl_if;
    logic       query_local;
    logic       query_remote;
    logic       done;
    logic       error;
    logic [7:0] byte0;
    logic [7:0] byte1;

    modport master (
        output query_local,
        output query_remote,
        input  done,
        input  error,
        input  byte0,
        input  byte1
    );

    modport slave (
        input  query_local,
        input  query_remote,
        output done,
        output error,
        output byte0,
        output byte1
    );
endinterface

// File: rtl/tmp421_sensor_ctrl.sv
// ---------------------------------------------------------------------------
// tmp421_sensor_ctrl
// Periodically reads the local and then the remote TMP421 temperature through
// the I2C transfer FSM, converts each byte pair into a sign-extended 12-bit
// value and raises a one-cycle CPU interrupt when either channel moved by more
// than a programmable threshold since the last reported value.
//
// Ports:
//   Clk_i                 system clock, rising edge
//   Reset_n_i             asynchronous active-low reset
//   Enable_i              1 = periodic sampling, 0 = halt
//   ParamCounterPreset_i  idle cycles between sampling rounds, minus 1
//   ParamThreshold_i      unsigned change threshold in 1/16 degC LSBs
//   bus                   handshake to the I2C FSM (master modport)
//   SensorValueL_o        last reported local temperature, sign-extended
//   SensorValueR_o        last reported remote temperature, sign-extended
//   CpuIntr_o             one-cycle interrupt pulse
// ---------------------------------------------------------------------------
module tmp421_sensor_ctrl #(
    parameter int TimerWidth = 16
) (
    input  logic                  Clk_i,
    input  logic                  Reset_n_i,
    input  logic                  Enable_i,
    input  logic [TimerWidth-1:0] ParamCounterPreset_i,
    input  logic [15:0]           ParamThreshold_i,
    tmp421_sensor_ctrl_if.master  bus,
    output logic [15:0]           SensorValueL_o,
    output logic [15:0]           SensorValueR_o,
    output logic                  CpuIntr_o
);

    typedef enum logic [2:0] {
        stDisabled,
        stIdle,
        stQueryLocal,
        stWaitLocal,
        stQueryRemote,
        stWaitRemote,
        stCompare,
        stNotify
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [TimerWidth-1:0]   timer;
    logic signed [15:0]      loc_new;
    logic signed [15:0]      rem_new;
    logic                    exceed;
    logic                    unused_low_nibble;

    // {Byte1, Byte0[7:4]} is a 12-bit two's complement value in 1/16 degC.
    function automatic logic signed [15:0] conv_temp(input logic [7:0] b1,
                                                     input logic [7:0] b0);
        return {{4{b1[7]}}, b1, b0[7:4]};
    endfunction

    // |a - b| evaluated in 17 bits so no difference of two 16-bit values overflows.
    function automatic logic [16:0] abs_diff(input logic [15:0] a,
                                             input logic [15:0] b);
        logic [16:0] d;
        d = {a[15], a} - {b[15], b};
        return d[16] ? (~d + 17'd1) : d;
    endfunction

    // The low nibble of byte0 carries no temperature information.
    assign unused_low_nibble = ^bus.byte0[3:0];

    assign exceed = (abs_diff(loc_new, SensorValueL_o) > {1'b0, ParamThreshold_i}) ||
                    (abs_diff(rem_new, SensorValueR_o) > {1'b0, ParamThreshold_i});

    always_comb begin
        state_nxt = state;
        if (!Enable_i) begin
            state_nxt = stDisabled;
        end else begin
            case (state)
                stDisabled:    state_nxt = stIdle;
                stIdle:        if (timer == '0) state_nxt = stQueryLocal;
                stQueryLocal:  state_nxt = stWaitLocal;
                stWaitLocal: begin
                    // error takes priority over a simultaneous done
                    if (bus.error)     state_nxt = stIdle;
                    else if (bus.done) state_nxt = stQueryRemote;
                end
                stQueryRemote: state_nxt = stWaitRemote;
                stWaitRemote: begin
                    if (bus.error)     state_nxt = stIdle;
                    else if (bus.done) state_nxt = stCompare;
                end
                stCompare:     state_nxt = exceed ? stNotify : stIdle;
                stNotify:      state_nxt = stIdle;
                default:       state_nxt = stDisabled;
            endcase
        end
    end

    always_ff @(posedge Clk_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            state            <= stDisabled;
            timer            <= '0;
            loc_new          <= '0;
            rem_new          <= '0;
            bus.query_local  <= 1'b0;
            bus.query_remote <= 1'b0;
            CpuIntr_o        <= 1'b0;
            SensorValueL_o   <= '0;
            SensorValueR_o   <= '0;
        end else begin
            state <= state_nxt;

            // Pulse outputs are registered copies of the state being entered.
            bus.query_local  <= (state_nxt == stQueryLocal);
            bus.query_remote <= (state_nxt == stQueryRemote);
            CpuIntr_o        <= (state_nxt == stNotify);

            // Every entry into stIdle restarts the full sampling period.
            if (state_nxt == stIdle && state != stIdle)
                timer <= ParamCounterPreset_i;
            else if (state == stIdle && timer != '0)
                timer <= timer - 1'b1;

            if (state == stWaitLocal && bus.done && !bus.error)
                loc_new <= conv_temp(bus.byte1, bus.byte0);
            if (state == stWaitRemote && bus.done && !bus.error)
                rem_new <= conv_temp(bus.byte1, bus.byte0);

            // Both channels are always reported together.
            if (state_nxt == stNotify) begin
                SensorValueL_o <= loc_new;
                SensorValueR_o <= rem_new;
            end
        end
    end

endmodule

// File: tb/tb_tmp421_sensor_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tmp421_sensor_ctrl
// Directed bench for tmp421_sensor_ctrl: periodic query timing, conversion,
// threshold boundary, negative values, abort paths, enable and reset handling.
// ---------------------------------------------------------------------------
module tb_tmp421_sensor_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [15:0] preset;
    logic [15:0] thr;
    logic [15:0] sv_l;
    logic [15:0] sv_r;
    logic        intr;

    int n_checks = 0;
    int n_pass   = 0;

    tmp421_sensor_ctrl_if bus();

    tmp421_sensor_ctrl #(.TimerWidth(16)) dut (
        .Clk_i                (clk),
        .Reset_n_i            (rst_n),
        .Enable_i             (en),
        .ParamCounterPreset_i (preset),
        .ParamThreshold_i     (thr),
        .bus                  (bus),
        .SensorValueL_o       (sv_l),
        .SensorValueR_o       (sv_r),
        .CpuIntr_o            (intr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until query_local is seen; n = cycles taken, intrs = interrupts seen.
    task automatic wait_ql(input int max, output int n, output int intrs);
        n = 0;
        intrs = 0;
        while (bus.query_local !== 1'b1 && n < max) begin
            tick();
            n++;
            if (intr === 1'b1) intrs++;
        end
    endtask

    // Count any query or interrupt activity over a number of cycles.
    task automatic quiet(input int cycles, output int act);
        act = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (bus.query_local !== 1'b0 || bus.query_remote !== 1'b0 || intr !== 1'b0)
                act++;
        end
    endtask

    // One full sampling round, entered in the cycle query_local is high (preset 5).
    task automatic round(input string tag,
                         input logic [7:0] l1, input logic [7:0] l0,
                         input logic [7:0] r1, input logic [7:0] r0,
                         input logic exp_intr,
                         input logic [15:0] exp_l, input logic [15:0] exp_r);
        int n;
        int intrs;
        tick();
        check({tag, "_ql_width"}, bus.query_local, 1'b0);
        bus.byte1 = l1; bus.byte0 = l0; bus.done = 1'b1;
        tick();
        check({tag, "_qr"}, bus.query_remote, 1'b1);
        bus.done = 1'b0;
        tick();
        check({tag, "_qr_width"}, bus.query_remote, 1'b0);
        bus.byte1 = r1; bus.byte0 = r0; bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        check({tag, "_intr_early"}, intr, 1'b0);
        tick();
        check({tag, "_intr"}, intr, exp_intr);
        check({tag, "_sv_l"}, sv_l, exp_l);
        check({tag, "_sv_r"}, sv_r, exp_r);
        tick();
        check({tag, "_intr_width"}, intr, 1'b0);
        wait_ql(50, n, intrs);
        check({tag, "_next_gap"}, n, exp_intr ? 6 : 5);
        check({tag, "_no_extra_intr"}, intrs, 0);
    endtask

    initial begin
        int n;
        int intrs;
        int act;

        rst_n = 1'b0; en = 1'b0; preset = 16'd5; thr = 16'h0100;
        bus.done = 1'b0; bus.error = 1'b0; bus.byte0 = 8'h00; bus.byte1 = 8'h00;

        #12;
        check("rst_ql", bus.query_local, 1'b0);
        check("rst_qr", bus.query_remote, 1'b0);
        check("rst_intr", intr, 1'b0);
        check("rst_sv_l", sv_l, 16'h0000);
        check("rst_sv_r", sv_r, 16'h0000);
        tick();
        rst_n = 1'b1;
        quiet(10, act);
        check("disabled_quiet", act, 0);

        // Enable: stIdle entry one cycle later, query 6 cycles after that.
        en = 1'b1;
        wait_ql(50, n, intrs);
        check("first_gap", n, 7);

        round("first",  8'h19, 8'h00, 8'h1E, 8'h80, 1'b1, 16'h0190, 16'h01E8);
        round("small",  8'h19, 8'h10, 8'h1E, 8'h80, 1'b0, 16'h0190, 16'h01E8);
        // Both channels change by exactly the threshold; low nibble garbage ignored.
        round("bound",  8'h29, 8'h0F, 8'h0E, 8'h80, 1'b0, 16'h0190, 16'h01E8);
        round("neg",    8'hF6, 8'h00, 8'h20, 8'h00, 1'b1, 16'hFF60, 16'h0200);
        // Remote alone moves by threshold+1.
        round("rem101", 8'hF6, 8'h00, 8'h30, 8'h10, 1'b1, 16'hFF60, 16'h0301);

        // Error while waiting for the remote reading.
        tick();
        bus.byte1 = 8'h10; bus.byte0 = 8'h00; bus.done = 1'b1;
        tick();
        check("abr_qr", bus.query_remote, 1'b1);
        bus.done = 1'b0;
        tick();
        bus.byte1 = 8'h7F; bus.byte0 = 8'hF0; bus.error = 1'b1;
        tick();
        bus.error = 1'b0;
        check("abr_intr", intr, 1'b0);
        wait_ql(50, n, intrs);
        check("abr_gap", n, 6);
        check("abr_no_intr", intrs, 0);
        check("abr_sv_l", sv_l, 16'hFF60);
        check("abr_sv_r", sv_r, 16'h0301);

        // Done and error together in the local wait: abort, no remote query.
        tick();
        bus.byte1 = 8'h7F; bus.byte0 = 8'h00; bus.done = 1'b1; bus.error = 1'b1;
        tick();
        bus.done = 1'b0; bus.error = 1'b0;
        check("both_no_qr", bus.query_remote, 1'b0);
        wait_ql(50, n, intrs);
        check("both_gap", n, 6);

        round("after", 8'hF6, 8'h05, 8'h30, 8'h10, 1'b0, 16'hFF60, 16'h0301);

        // Disable in the local wait, then a late done must be ignored.
        tick();
        en = 1'b0;
        tick();
        check("dis_ql", bus.query_local, 1'b0);
        bus.byte1 = 8'h7F; bus.byte0 = 8'h00; bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        quiet(20, act);
        check("dis_late_done", act, 0);
        check("dis_sv_l", sv_l, 16'hFF60);
        check("dis_sv_r", sv_r, 16'h0301);

        en = 1'b1;
        wait_ql(50, n, intrs);
        check("reen_gap", n, 7);

        // Large change, but disable arrives in the compare cycle: no interrupt.
        tick();
        bus.byte1 = 8'h7F; bus.byte0 = 8'h00; bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        tick();
        bus.byte1 = 8'h80; bus.byte0 = 8'h00; bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        en = 1'b0;
        tick();
        check("sup_intr", intr, 1'b0);
        check("sup_sv_l", sv_l, 16'hFF60);
        check("sup_sv_r", sv_r, 16'h0301);
        tick();
        check("sup_intr2", intr, 1'b0);

        // Preset 0: one-cycle idle gap.
        preset = 16'd0;
        en = 1'b1;
        wait_ql(50, n, intrs);
        check("p0_gap", n, 2);
        tick();
        bus.error = 1'b1;
        tick();
        bus.error = 1'b0;
        wait_ql(50, n, intrs);
        check("p0_err_gap", n, 1);

        // Asynchronous reset in the middle of the remote wait.
        preset = 16'd5;
        tick();
        bus.byte1 = 8'h12; bus.byte0 = 8'h00; bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ql", bus.query_local, 1'b0);
        check("arst_qr", bus.query_remote, 1'b0);
        check("arst_intr", intr, 1'b0);
        check("arst_sv_l", sv_l, 16'h0000);
        check("arst_sv_r", sv_r, 16'h0000);
        en = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        quiet(20, act);
        check("arst_quiet", act, 0);
        en = 1'b1;
        wait_ql(50, n, intrs);
        check("arst_reen_gap", n, 7);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
